// File: rtl/sz_quant_encode_if.sv
// Stream bundle for sz_quant_encode: input beat (|error|, sign) and output beat (code, flag, data).
interface sz_quant_encode_if #(
  parameter int unsigned QUANT_BINS = 65536
);
  localparam int unsigned CW = $clog2(QUANT_BINS);

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_sign;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_code;
  logic          out_unpred;
  logic [31:0]   out_data;

  modport master (
    output in_valid, in_data, in_sign, out_ready,
    input  in_ready, out_valid, out_code, out_unpred, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sign, out_ready,
    output in_ready, out_valid, out_code, out_unpred, out_data
  );
endinterface

// File: rtl/sz_quant_encode.sv
// SZ linear-scaling quantization encoder, 2-stage valid/ready pipeline.
// Optional saturating statistics counters enabled by macro SZ_QUANT_STAT_EN.
module sz_quant_encode #(
  parameter int unsigned QUANT_BINS = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  eb_exp,
`ifdef SZ_QUANT_STAT_EN
  input  logic        stat_clr,
  output logic [31:0] stat_total,
  output logic [31:0] stat_unpred,
`endif
  sz_quant_encode_if.slave bus
);
  localparam int unsigned CW   = $clog2(QUANT_BINS);
  localparam int unsigned HALF = QUANT_BINS / 2;
  localparam int unsigned HB   = CW - 1;

  logic                r_init;
  logic                r_s1_valid;
  logic                r_s1_unpred;
  logic                r_s1_zero;
  logic                r_s1_one;
  logic [23:0]         r_s1_m;
  logic [3:0]          r_s1_sh;
  logic                r_s1_sign;
  logic [31:0]         r_s1_data;

  logic                r_s2_valid;
  logic [CW-1:0]       r_code;
  logic                r_unpred;
  logic [31:0]         r_data;

  logic                w_s2_ready;
  logic                w_in_ready;
  logic                w_accept;
  logic [7:0]          w_e;
  logic signed [9:0]   w_s;
  logic                w_d_unpred;
  logic                w_d_zero;
  logic                w_d_one;
  logic [24:0]         w_sum;
  logic [24:0]         w_k;
  logic                w_unpred;
  logic [CW-1:0]       w_code;

  assign w_s2_ready = ~r_s2_valid | bus.out_ready;
  // r_init holds in_ready low until the first edge after reset release
  assign w_in_ready = r_init & (~r_s1_valid | w_s2_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign bus.in_ready = w_in_ready;

  assign w_e = bus.in_data[30:23];
  assign w_s = $signed({2'b00, w_e}) - $signed({2'b00, eb_exp}) - 10'sd1;

  always_comb begin
    w_d_unpred = 1'b0;
    w_d_zero   = 1'b0;
    w_d_one    = 1'b0;
    if (eb_exp == 8'd0 || eb_exp == 8'd255 || w_e == 8'd255)
      w_d_unpred = 1'b1;
    else if (w_e == 8'd0 || w_s < -10'sd1)
      w_d_zero = 1'b1;
    else if (w_s == -10'sd1)
      w_d_one = 1'b1;
    else if (w_s >= $signed(10'(HB)))
      w_d_unpred = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init      <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_unpred <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_one    <= 1'b0;
      r_s1_m      <= '0;
      r_s1_sh     <= '0;
      r_s1_sign   <= 1'b0;
      r_s1_data   <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_in_ready)
        r_s1_valid <= bus.in_valid;
      if (w_accept) begin
        r_s1_unpred <= w_d_unpred;
        r_s1_zero   <= w_d_zero;
        r_s1_one    <= w_d_one;
        r_s1_m      <= {1'b1, bus.in_data[22:0]};
        r_s1_sh     <= w_s[3:0];
        r_s1_sign   <= bus.in_sign;
        r_s1_data   <= bus.in_data;
      end
    end
  end

  // Round-half-up of M * 2^(s-23): add half an LSB before the right shift
  assign w_sum = {1'b0, r_s1_m} + (25'd1 << (5'd22 - {1'b0, r_s1_sh}));

  always_comb begin
    if (r_s1_zero)
      w_k = '0;
    else if (r_s1_one)
      w_k = 25'd1;
    else
      w_k = w_sum >> (5'd23 - {1'b0, r_s1_sh});
  end

  assign w_unpred = r_s1_unpred | (w_k >= 25'(HALF));

  always_comb begin
    if (w_unpred)
      w_code = '0;
    else if (r_s1_sign)
      w_code = CW'(HALF) - w_k[CW-1:0];
    else
      w_code = CW'(HALF) + w_k[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_code     <= '0;
      r_unpred   <= 1'b0;
      r_data     <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_code   <= w_code;
        r_unpred <= w_unpred;
        r_data   <= r_s1_data;
      end
    end
  end

  assign bus.out_valid  = r_s2_valid;
  assign bus.out_code   = r_code;
  assign bus.out_unpred = r_unpred;
  assign bus.out_data   = r_data;

`ifdef SZ_QUANT_STAT_EN
  logic [31:0] r_stat_total;
  logic [31:0] r_stat_unpred;
  logic        w_out_hs;

  assign w_out_hs = r_s2_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_total  <= '0;
      r_stat_unpred <= '0;
    end else if (stat_clr) begin
      r_stat_total  <= '0;
      r_stat_unpred <= '0;
    end else if (w_out_hs) begin
      if (r_stat_total != '1)
        r_stat_total <= r_stat_total + 32'd1;
      if (r_unpred && r_stat_unpred != '1)
        r_stat_unpred <= r_stat_unpred + 32'd1;
    end
  end

  assign stat_total  = r_stat_total;
  assign stat_unpred = r_stat_unpred;
`endif
endmodule

// File: tb/tb_sz_quant_encode.sv
// Scoreboard bench for sz_quant_encode: directed vectors, random back-pressure, mid-stream reset.
module tb_sz_quant_encode;
  typedef struct {
    logic [7:0]  eb;
    logic [31:0] d;
    logic        s;
    logic [15:0] code;
    logic        unp;
  } vec_t;

  typedef struct {
    logic [15:0] code;
    logic        unp;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  eb_exp;
  int          tests;
  int          fails;
  int          or_mode;
  int          hs_cnt;
  int          unp_cnt;
  exp_t        q[$];
  vec_t        V[19];

  sz_quant_encode_if #(.QUANT_BINS(65536)) bus ();

`ifdef SZ_QUANT_STAT_EN
  logic        stat_clr;
  logic [31:0] stat_total;
  logic [31:0] stat_unpred;
`endif

  sz_quant_encode #(.QUANT_BINS(65536)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .eb_exp      (eb_exp),
`ifdef SZ_QUANT_STAT_EN
    .stat_clr    (stat_clr),
    .stat_total  (stat_total),
    .stat_unpred (stat_unpred),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output handshake, checks hold stability
  initial begin
    logic        hold;
    logic [15:0] h_code;
    logic        h_unp;
    logic [31:0] h_d;
    exp_t        e;
    hold = 1'b0;
    h_code = '0; h_unp = 1'b0; h_d = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", bus.out_valid, 1'b1);
          check("hold_code", bus.out_code, h_code);
          check("hold_unpred", bus.out_unpred, h_unp);
          check("hold_data", bus.out_data, h_d);
        end
        if (bus.out_valid && bus.out_ready) begin
          check("expected_pending", q.size() != 0, 1'b1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("out_code", bus.out_code, e.code);
            check("out_unpred", bus.out_unpred, e.unp);
            check("out_data", bus.out_data, e.d);
            hs_cnt++;
            if (e.unp) unp_cnt++;
          end
        end
        hold   = bus.out_valid & ~bus.out_ready;
        h_code = bus.out_code;
        h_unp  = bus.out_unpred;
        h_d    = bus.out_data;
      end
    end
  end

  task automatic send(input int idx, input bit chk_lat);
    bit   ok;
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = V[idx].d;
    bus.in_sign  = V[idx].s;
    eb_exp       = V[idx].eb;
    ok = 1'b0;
    for (int w = 0; w < 200; w++) begin
      #1;
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("in_ready_timeout", 1'b0, 1'b1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.code = V[idx].code;
      e.unp  = V[idx].unp;
      e.d    = V[idx].d;
      q.push_back(e);
      #1;
      bus.in_valid = 1'b0;
      eb_exp = 8'hA5;
      if (chk_lat) begin
        check("lat_cycle1_idle", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_cycle2_valid", bus.out_valid, 1'b1);
      end
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    #4;
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    tests = 0; fails = 0; or_mode = 0; hs_cnt = 0; unp_cnt = 0;
    V[0]  = '{8'd117, 32'h00000000, 1'b0, 16'd32768, 1'b0};
    V[1]  = '{8'd117, 32'h3BC00000, 1'b0, 16'd32771, 1'b0};
    V[2]  = '{8'd117, 32'h3BC00000, 1'b1, 16'd32765, 1'b0};
    V[3]  = '{8'd117, 32'h3BA00000, 1'b0, 16'd32771, 1'b0};
    V[4]  = '{8'd117, 32'h3F800000, 1'b0, 16'd33280, 1'b0};
    V[5]  = '{8'd117, 32'h42800000, 1'b0, 16'd0,     1'b1};
    V[6]  = '{8'd117, 32'h7F800000, 1'b0, 16'd0,     1'b1};
    V[7]  = '{8'd0,   32'h3F800000, 1'b0, 16'd0,     1'b1};
    V[8]  = '{8'd255, 32'h00000000, 1'b0, 16'd0,     1'b1};
    V[9]  = '{8'd117, 32'h3A800000, 1'b0, 16'd32769, 1'b0};
    V[10] = '{8'd117, 32'h3A800000, 1'b1, 16'd32767, 1'b0};
    V[11] = '{8'd117, 32'h3A000000, 1'b1, 16'd32768, 1'b0};
    V[12] = '{8'd117, 32'h427FFEFF, 1'b0, 16'd65535, 1'b0};
    V[13] = '{8'd117, 32'h427FFEFF, 1'b1, 16'd1,     1'b0};
    V[14] = '{8'd117, 32'h427FFF00, 1'b1, 16'd0,     1'b1};
    V[15] = '{8'd127, 32'h3F800000, 1'b1, 16'd32767, 1'b0};
    V[16] = '{8'd100, 32'h3F800000, 1'b0, 16'd0,     1'b1};
    V[17] = '{8'd117, 32'hBF800000, 1'b1, 16'd32256, 1'b0};
    V[18] = '{8'd117, 32'h00000001, 1'b1, 16'd32768, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sign  = 1'b0;
    eb_exp       = 8'd117;
`ifdef SZ_QUANT_STAT_EN
    stat_clr = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_code", bus.out_code, 16'd0);
    check("rst_out_unpred", bus.out_unpred, 1'b0);
    check("rst_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 19; i++) send(i, 1'b1);
    drain();

    or_mode = 1;
    for (int i = 0; i < 16; i++) send((i * 7) % 19, 1'b0);
    drain();

    or_mode = 2;
    send(1, 1'b0);
    send(4, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_code", bus.out_code, 16'd0);
    check("midrst_out_data", bus.out_data, 32'd0);
    q.delete();
    hs_cnt = 0;
    unp_cnt = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    or_mode = 0;
    send(12, 1'b1);
    send(5, 1'b1);
    drain();

`ifdef SZ_QUANT_STAT_EN
    check("stat_total", stat_total, 32'(hs_cnt));
    check("stat_unpred", stat_unpred, 32'(unp_cnt));
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("stat_total_clr", stat_total, 32'd0);
    check("stat_unpred_clr", stat_unpred, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
